uart_rx_ctrl: RTL and testbench

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_rx_ctrl.sv | 156 +++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: drains a UART receiver into a byte FIFO with error flags.
// A 3-state Moore handshake acknowledges each byte via read; the FIFO
// presents the head as a valid/ready stream and counts errored bytes.
module uart_rx_ctrl #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned ECW   = 8
) (
   input  logic                     mclkx16,
   input  logic                     reset,
   input  logic                     rxrdy,
   input  logic [7:0]               rdata,
   input  logic                     parityerr,
   input  logic                     framingerr,
   input  logic                     overrun,
   output logic                     read,
   input  logic                     flush,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [7:0]               m_data,
   output logic [2:0]               m_err,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty,
   output logic [ECW-1:0]           err_count,
   output logic                     ack_err
);

   localparam int unsigned AW        = $clog2(DEPTH);
   localparam int unsigned LW        = AW + 1;
   localparam int unsigned EW        = 11;
   localparam int unsigned CW        = 4;
   localparam int unsigned WAIT_LAST = 14;

   typedef enum logic [1:0] {IDLE, ACK, WAIT_CLR} state_t;

   state_t           state_q;
   logic             read_q;
   logic [CW-1:0]    wcnt_q;
   logic             ack_err_q;
   logic [ECW-1:0]   err_count_q;

   logic [EW-1:0]    mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;

   logic             full_c;
   logic             push_c;
   logic             pop_c;
   logic [2:0]       flags_c;
   logic [EW-1:0]    head_c;

   assign flags_c = {overrun, framingerr, parityerr};
   assign full_c  = (level_q == LW'(DEPTH));
   assign push_c  = (state_q == IDLE) && rxrdy && !full_c;
   assign pop_c   = (level_q != '0) && m_ready;
   assign head_c  = mem_q[rd_ptr_q];

   // Handshake FSM: accept a byte in IDLE, hold read through ACK/WAIT_CLR
   always_ff @(posedge mclkx16 or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         read_q    <= 1'b0;
         wcnt_q    <= '0;
         ack_err_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (push_c) begin
                  state_q <= ACK;
                  read_q  <= 1'b1;
               end
            end
            ACK: begin
               state_q <= WAIT_CLR;
               wcnt_q  <= '0;
            end
            WAIT_CLR: begin
               if (!rxrdy) begin
                  state_q <= IDLE;
                  read_q  <= 1'b0;
               end else if (wcnt_q == CW'(WAIT_LAST)) begin
                  // receiver never dropped rxrdy: give up and flag it
                  ack_err_q <= 1'b1;
                  state_q   <= IDLE;
                  read_q    <= 1'b0;
               end else begin
                  wcnt_q <= wcnt_q + CW'(1);
               end
            end
            default: begin
               state_q <= IDLE;
               read_q  <= 1'b0;
            end
         endcase
      end
   end

   // FIFO next-state: flush wins over any same-cycle push or pop
   always_comb begin
      level_d  = level_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush) begin
         level_d  = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push_c) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop_c)  rd_ptr_d = rd_ptr_q + AW'(1);
         case ({push_c, pop_c})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
         endcase
      end
   end

   // FIFO pointer and occupancy registers
   always_ff @(posedge mclkx16 or posedge reset) begin
      if (reset) begin
         level_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         level_q  <= level_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // FIFO storage, deliberately unreset
   always_ff @(posedge mclkx16) begin
      if (push_c) mem_q[wr_ptr_q] <= {flags_c, rdata};
   end

   // Saturating count of accepted bytes carrying any error flag
   always_ff @(posedge mclkx16 or posedge reset) begin
      if (reset) begin
         err_count_q <= '0;
      end else if (push_c && (flags_c != 3'b000) && (err_count_q != '1)) begin
         err_count_q <= err_count_q + ECW'(1);
      end
   end

   assign read      = read_q;
   assign ack_err   = ack_err_q;
   assign err_count = err_count_q;
   assign level     = level_q;
   assign full      = full_c;
   assign empty     = (level_q == '0);
   assign m_valid   = (level_q != '0);
   assign m_data    = head_c[7:0];
   assign m_err     = head_c[10:8];

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: handshake, fill/full, flags, wrap, timeout, flush, reset.
module tb_uart_rx_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       rxrdy;
   logic [7:0] rdata;
   logic       parityerr, framingerr, overrun;
   logic       read;
   logic       flush;
   logic       m_valid;
   logic       m_ready;
   logic [7:0] m_data;
   logic [2:0] m_err;
   logic [3:0] level;
   logic       full, empty;
   logic [7:0] err_count;
   logic       ack_err;

   int n_chk = 0;
   int n_err = 0;

   uart_rx_ctrl #(.DEPTH(8), .ECW(8)) dut (
      .mclkx16    (clk),
      .reset      (reset),
      .rxrdy      (rxrdy),
      .rdata      (rdata),
      .parityerr  (parityerr),
      .framingerr (framingerr),
      .overrun    (overrun),
      .read       (read),
      .flush      (flush),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .m_err      (m_err),
      .level      (level),
      .full       (full),
      .empty      (empty),
      .err_count  (err_count),
      .ack_err    (ack_err)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Present a byte like the receiver would; drop rxrdy once read rises
   task automatic offer(input logic [7:0] d, input logic [2:0] f);
      int n;
      rxrdy = 1'b1;
      rdata = d;
      {overrun, framingerr, parityerr} = f;
      n = 0;
      do begin tick(); n++; end while (!read && n < 4);
      chk("offer_ack", 32'(read), 32'd1);
      rxrdy = 1'b0;
      n = 0;
      while (read && n < 20) begin tick(); n++; end
      chk("offer_rel", 32'(read), 32'd0);
   endtask

   initial begin
      int n;
      logic [7:0] exp_q [$];
      reset = 1'b1; rxrdy = 1'b0; rdata = 8'h00;
      parityerr = 1'b0; framingerr = 1'b0; overrun = 1'b0;
      flush = 1'b0; m_ready = 1'b0;

      // reset state
      tick(); tick();
      chk("rst_read",   32'(read),      32'd0);
      chk("rst_valid",  32'(m_valid),   32'd0);
      chk("rst_full",   32'(full),      32'd0);
      chk("rst_empty",  32'(empty),     32'd1);
      chk("rst_level",  32'(level),     32'd0);
      chk("rst_errcnt", 32'(err_count), 32'd0);
      chk("rst_ackerr", 32'(ack_err),   32'd0);
      reset = 1'b0;
      tick();

      // single byte
      rxrdy = 1'b1; rdata = 8'hA5;
      tick();
      chk("single_read_ack", 32'(read),      32'd1);
      chk("single_valid",    32'(m_valid),   32'd1);
      chk("single_data",     32'(m_data),    32'hA5);
      chk("single_err",      32'(m_err),     32'd0);
      chk("single_level",    32'(level),     32'd1);
      chk("single_errcnt",   32'(err_count), 32'd0);
      rxrdy = 1'b0;
      tick();
      chk("single_read_wait", 32'(read), 32'd1);
      tick();
      chk("single_read_idle", 32'(read), 32'd0);
      m_ready = 1'b1; tick(); m_ready = 1'b0;
      chk("single_pop_empty", 32'(empty), 32'd1);

      // fill to full, 9th byte held off until a pop
      for (int i = 0; i < 8; i++) offer(8'(8'h10 + i), 3'b000);
      chk("fill_full",  32'(full),  32'd1);
      chk("fill_level", 32'(level), 32'd8);
      rxrdy = 1'b1; rdata = 8'h99;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("fill_no_ack",  32'(read),   32'd0);
         chk("fill_hold",    32'(level),  32'd8);
         chk("fill_stable",  32'(m_data), 32'h10);
      end
      m_ready = 1'b1; tick(); m_ready = 1'b0;
      chk("fill_pop_level", 32'(level),  32'd7);
      chk("fill_pop_head",  32'(m_data), 32'h11);
      n = 0;
      while (!read && n < 2) begin tick(); n++; end
      chk("fill_9th_ack", 32'(read), 32'd1);
      rxrdy = 1'b0;
      n = 0;
      while (read && n < 20) begin tick(); n++; end
      chk("fill_9th_level", 32'(level), 32'd8);
      m_ready = 1'b1;
      for (int i = 1; i < 9; i++) begin
         chk("fill_order", 32'(m_data), (i == 8) ? 32'h99 : 32'(8'h10 + i));
         tick();
      end
      m_ready = 1'b0;
      chk("fill_drained", 32'(empty), 32'd1);

      // error flags
      offer(8'h3C, 3'b010);
      offer(8'h00, 3'b101);
      chk("flag_errcnt", 32'(err_count), 32'd2);
      chk("flag_data0",  32'(m_data),    32'h3C);
      chk("flag_err0",   32'(m_err),     32'b010);
      m_ready = 1'b1; tick();
      chk("flag_data1",  32'(m_data),    32'h00);
      chk("flag_err1",   32'(m_err),     32'b101);
      tick(); m_ready = 1'b0;
      chk("flag_empty",  32'(empty),     32'd1);

      // simultaneous push and pop at level 3, wrapping across 20 bytes
      for (int i = 0; i < 3; i++) begin
         offer(8'(8'h40 + i), 3'b000);
         exp_q.push_back(8'(8'h40 + i));
      end
      chk("wrap_start_level", 32'(level), 32'd3);
      for (int k = 0; k < 20; k++) begin
         rxrdy = 1'b1; rdata = 8'(8'h43 + k); m_ready = 1'b1;
         exp_q.push_back(8'(8'h43 + k));
         chk("wrap_head", 32'(m_data), 32'(exp_q.pop_front()));
         tick();
         chk("wrap_level", 32'(level), 32'd3);
         m_ready = 1'b0; rxrdy = 1'b0;
         tick(); tick();
      end
      m_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("wrap_tail", 32'(m_data), 32'(exp_q.pop_front()));
         tick();
      end
      m_ready = 1'b0;
      chk("wrap_empty", 32'(empty), 32'd1);

      // stuck rxrdy: one push, timeout after 15 WAIT_CLR cycles, re-push
      rxrdy = 1'b1; rdata = 8'h77;
      tick();
      chk("stuck_push1", 32'(level), 32'd1);
      for (int i = 0; i < 15; i++) tick();
      chk("stuck_pre_ackerr", 32'(ack_err), 32'd0);
      chk("stuck_pre_read",   32'(read),    32'd1);
      chk("stuck_one_push",   32'(level),   32'd1);
      tick();
      chk("stuck_ackerr", 32'(ack_err), 32'd1);
      chk("stuck_idle",   32'(read),    32'd0);
      tick();
      chk("stuck_push2",  32'(level),   32'd2);
      chk("stuck_read2",  32'(read),    32'd1);
      rxrdy = 1'b0;
      n = 0;
      while (read && n < 20) begin tick(); n++; end
      m_ready = 1'b1; tick(); tick(); m_ready = 1'b0;

      // flush at level 5 with a same-cycle pop
      for (int i = 0; i < 5; i++) offer(8'(8'h60 + i), 3'b000);
      chk("flush_pre_level", 32'(level), 32'd5);
      flush = 1'b1; m_ready = 1'b1;
      tick();
      flush = 1'b0; m_ready = 1'b0;
      chk("flush_level",  32'(level),   32'd0);
      chk("flush_empty",  32'(empty),   32'd1);
      chk("flush_valid",  32'(m_valid), 32'd0);
      chk("flush_ackerr", 32'(ack_err), 32'd1);

      // push in a flush cycle: acknowledged, discarded, still counted
      rxrdy = 1'b1; rdata = 8'hEE; {overrun, framingerr, parityerr} = 3'b001; flush = 1'b1;
      tick();
      flush = 1'b0; rxrdy = 1'b0; {overrun, framingerr, parityerr} = 3'b000;
      chk("flushpush_read",   32'(read),      32'd1);
      chk("flushpush_level",  32'(level),     32'd0);
      chk("flushpush_errcnt", 32'(err_count), 32'd3);
      n = 0;
      while (read && n < 20) begin tick(); n++; end

      // reset asserted in WAIT_CLR takes effect without a clock edge
      offer(8'h21, 3'b000);
      rxrdy = 1'b1; rdata = 8'h22;
      tick(); tick(); tick();
      chk("midrst_pre_read", 32'(read), 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("midrst_read",    32'(read),      32'd0);
      chk("midrst_level",   32'(level),     32'd0);
      chk("midrst_empty",   32'(empty),     32'd1);
      chk("midrst_ackerr",  32'(ack_err),   32'd0);
      chk("midrst_errcnt",  32'(err_count), 32'd0);
      rxrdy = 1'b0;
      tick();
      reset = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
